// File: rtl/elev_pkg.sv
// rtl/elev_pkg.sv - shared state, run-mode and floor encodings for the elevator car
package elev_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MOVE   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_DOOR   = 3'd3,
    ST_RESUME = 3'd4
  } state_e;

  localparam logic [1:0] UD_STOP = 2'b00;
  localparam logic [1:0] UD_UP   = 2'b01;
  localparam logic [1:0] UD_DOWN = 2'b10;

  localparam logic [3:0] FLOOR_BOT = 4'b0001;
  localparam logic [3:0] FLOOR_TOP = 4'b1000;

endpackage

// File: rtl/travel_timer.sv
// rtl/travel_timer.sv - per-floor travel counter with done pulse on the last count
module travel_timer #(
  parameter int TRAVEL_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic freeze,
  output logic done
);

  localparam int W = (TRAVEL_CYCLES > 2) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TRAVEL_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // start holds the counter at zero until travel begins; done only fires while running
  assign done = !start && !freeze && (cnt_q == LAST);

  // next count: hold while frozen, wrap to zero at the end of each floor
  always_comb begin
    cnt_d = cnt_q;
    if (!freeze) begin
      if (start || done) cnt_d = '0;
      else               cnt_d = cnt_q + W'(1);
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/car_motion_ctrl.sv
// rtl/car_motion_ctrl.sv - car motion and door sequencer; ESTOP_EN adds the estop freeze input
module car_motion_ctrl
  import elev_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 64,
  parameter int FLOORS        = 4
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ESTOP_EN
  input  logic              estop,
`endif
  input  logic              up_need,
  input  logic              down_need,
  input  logic [FLOORS-1:0] allReq,
  input  logic              endOpen,
  output logic [FLOORS-1:0] position,
  output logic [1:0]        ud_mode,
  output logic              StOpen,
  output logic [FLOORS-1:0] arrive_clr,
  output logic              moving
);

  state_e            state_q, state_d;
  logic [FLOORS-1:0] pos_q, pos_d;
  logic [1:0]        ud_q, ud_d;
  logic              st_q, st_d;
  logic [FLOORS-1:0] ar_q, ar_d;
  logic              frozen;
  logic              done;
  logic              here_req, can_up, can_down, same_dir, opp_dir;

`ifdef ESTOP_EN
  assign frozen = estop;
`else
  assign frozen = 1'b0;
`endif

  travel_timer #(.TRAVEL_CYCLES(TRAVEL_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (state_q != ST_MOVE),
    .freeze (frozen),
    .done   (done)
  );

  // end-floor guards keep position one-hot: never move up from the top or down from the bottom
  assign here_req = |(allReq & pos_q);
  assign can_up   = up_need   && (pos_q != FLOOR_TOP);
  assign can_down = down_need && (pos_q != FLOOR_BOT);
  assign same_dir = ((ud_q == UD_UP) && can_up) || ((ud_q == UD_DOWN) && can_down);
  assign opp_dir  = ((ud_q == UD_UP) && can_down) || ((ud_q == UD_DOWN) && can_up);

  // next state and registered outputs; everything holds while frozen
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    ud_d    = ud_q;
    st_d    = st_q;
    ar_d    = '0;
    if (!frozen) begin
      case (state_q)
        ST_IDLE: begin
          ud_d = UD_STOP;
          if (here_req) begin
            state_d = ST_DOOR;
            st_d    = 1'b1;
            ar_d    = pos_q;
          end else if (can_up) begin
            state_d = ST_MOVE;
            ud_d    = UD_UP;
          end else if (can_down) begin
            state_d = ST_MOVE;
            ud_d    = UD_DOWN;
          end
        end
        ST_MOVE: begin
          if (done) begin
            pos_d   = (ud_q == UD_UP) ? (pos_q << 1) : (pos_q >> 1);
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (here_req) begin
            state_d = ST_DOOR;
            st_d    = 1'b1;
            ar_d    = pos_q;
          end else if (same_dir) begin
            state_d = ST_MOVE;
          end else begin
            state_d = ST_IDLE;
            ud_d    = UD_STOP;
          end
        end
        ST_DOOR: begin
          if (endOpen) begin
            st_d    = 1'b0;
            state_d = ST_RESUME;
          end
        end
        ST_RESUME: begin
          if (same_dir) begin
            state_d = ST_MOVE;
          end else if (opp_dir) begin
            state_d = ST_MOVE;
            ud_d    = (ud_q == UD_UP) ? UD_DOWN : UD_UP;
          end else begin
            state_d = ST_IDLE;
            ud_d    = UD_STOP;
          end
        end
        default: begin
          state_d = ST_IDLE;
          ud_d    = UD_STOP;
          st_d    = 1'b0;
        end
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pos_q   <= FLOOR_BOT;
      ud_q    <= UD_STOP;
      st_q    <= 1'b0;
      ar_q    <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      ud_q    <= ud_d;
      st_q    <= st_d;
      ar_q    <= ar_d;
    end
  end

  assign position   = pos_q;
  assign ud_mode    = ud_q;
  assign StOpen     = st_q;
  assign arrive_clr = ar_q;
  assign moving     = (state_q == ST_MOVE) && !frozen;

endmodule

// File: tb/tb_car_motion_ctrl.sv
// tb/tb_car_motion_ctrl.sv - directed vector bench for car_motion_ctrl
module tb_car_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       up_need, down_need, endOpen;
  logic [3:0] allReq;
  logic [3:0] position, arrive_clr;
  logic [1:0] ud_mode;
  logic       StOpen, moving;
`ifdef ESTOP_EN
  logic       estop;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         n;
    logic       up;
    logic       dn;
    logic [3:0] req;
    logic       eo;
    logic [3:0] pos;
    logic [1:0] ud;
    logic       st;
    logic [3:0] ar;
    logic       mv;
  } vec_t;

  vec_t vecs[17];

  car_motion_ctrl #(.TRAVEL_CYCLES(64), .FLOORS(4)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef ESTOP_EN
    .estop      (estop),
`endif
    .up_need    (up_need),
    .down_need  (down_need),
    .allReq     (allReq),
    .endOpen    (endOpen),
    .position   (position),
    .ud_mode    (ud_mode),
    .StOpen     (StOpen),
    .arrive_clr (arrive_clr),
    .moving     (moving)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string nm, input string fld, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %b expected %b", nm, fld, got, exp);
    end
  endtask

  task automatic chk(input string nm, input logic [3:0] ep, input logic [1:0] eu,
                     input logic es, input logic [3:0] ea, input logic em);
    cmp(nm, "position", position, ep);
    cmp(nm, "ud_mode", {2'b00, ud_mode}, {2'b00, eu});
    cmp(nm, "StOpen", {3'b000, StOpen}, {3'b000, es});
    cmp(nm, "arrive_clr", arrive_clr, ea);
    cmp(nm, "moving", {3'b000, moving}, {3'b000, em});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    up_need = 1'b0; down_need = 1'b0; allReq = 4'b0000; endOpen = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    int edges;
`ifdef ESTOP_EN
    estop = 1'b0;
`endif
    //            n   up dn req     eo  pos     ud     st ar      mv
    vecs[0]  = '{ 1,  0, 0, 4'b0000, 0, 4'b0001, 2'b00, 0, 4'b0000, 0};
    vecs[1]  = '{ 1,  1, 0, 4'b0100, 0, 4'b0001, 2'b01, 0, 4'b0000, 1};
    vecs[2]  = '{63,  1, 0, 4'b0100, 0, 4'b0001, 2'b01, 0, 4'b0000, 1};
    vecs[3]  = '{ 1,  1, 0, 4'b0100, 0, 4'b0010, 2'b01, 0, 4'b0000, 0};
    vecs[4]  = '{ 1,  1, 0, 4'b0100, 0, 4'b0010, 2'b01, 0, 4'b0000, 1};
    vecs[5]  = '{63,  1, 0, 4'b0100, 0, 4'b0010, 2'b01, 0, 4'b0000, 1};
    vecs[6]  = '{ 1,  1, 0, 4'b0100, 0, 4'b0100, 2'b01, 0, 4'b0000, 0};
    vecs[7]  = '{ 1,  1, 0, 4'b0100, 0, 4'b0100, 2'b01, 1, 4'b0100, 0};
    vecs[8]  = '{ 1,  0, 1, 4'b0000, 0, 4'b0100, 2'b01, 1, 4'b0000, 0};
    vecs[9]  = '{ 5,  0, 1, 4'b0000, 0, 4'b0100, 2'b01, 1, 4'b0000, 0};
    vecs[10] = '{ 1,  0, 1, 4'b0000, 1, 4'b0100, 2'b01, 0, 4'b0000, 0};
    vecs[11] = '{ 1,  0, 1, 4'b0000, 0, 4'b0100, 2'b10, 0, 4'b0000, 1};
    vecs[12] = '{63,  0, 1, 4'b0000, 0, 4'b0100, 2'b10, 0, 4'b0000, 1};
    vecs[13] = '{ 1,  0, 1, 4'b0000, 0, 4'b0010, 2'b10, 0, 4'b0000, 0};
    vecs[14] = '{ 1,  0, 0, 4'b0000, 0, 4'b0010, 2'b00, 0, 4'b0000, 0};
    vecs[15] = '{ 1,  0, 0, 4'b0000, 1, 4'b0010, 2'b00, 0, 4'b0000, 0};
    vecs[16] = '{ 1,  1, 1, 4'b0000, 0, 4'b0010, 2'b01, 0, 4'b0000, 1};

    do_reset();
    chk("reset", 4'b0001, 2'b00, 1'b0, 4'b0000, 1'b0);

    for (int i = 0; i < 17; i++) begin
      up_need = vecs[i].up; down_need = vecs[i].dn;
      allReq = vecs[i].req; endOpen = vecs[i].eo;
      step(vecs[i].n);
      chk($sformatf("vec%0d", i), vecs[i].pos, vecs[i].ud, vecs[i].st, vecs[i].ar, vecs[i].mv);
    end

    // door at floor 1 straight from IDLE
    do_reset();
    allReq = 4'b0001;
    step(1);
    chk("f1_door_entry", 4'b0001, 2'b00, 1'b1, 4'b0001, 1'b0);
    allReq = 4'b0000;
    step(1);
    chk("f1_door_hold", 4'b0001, 2'b00, 1'b1, 4'b0000, 1'b0);
    endOpen = 1'b1;
    step(1);
    chk("f1_resume", 4'b0001, 2'b00, 1'b0, 4'b0000, 1'b0);
    endOpen = 1'b0;
    step(1);
    chk("f1_idle", 4'b0001, 2'b00, 1'b0, 4'b0000, 1'b0);

    // run to floor 4, then up_need there must not start a move
    up_need = 1'b1; allReq = 4'b1000;
    edges = 0;
    while (position !== 4'b1000 && edges < 400) begin
      step(1);
      edges++;
    end
    cmp("to_top_edges", "edges", edges[3:0], 4'(195));
    n_cmp++;
    if (edges != 195) begin
      n_err++;
      $display("FAIL to_top_count: got %0d edges expected 195", edges);
    end
    allReq = 4'b0000;
    step(6);
    chk("top_guard", 4'b1000, 2'b00, 1'b0, 4'b0000, 1'b0);

    // reset at travel count 30 between floors 2 and 3
    do_reset();
    up_need = 1'b1; allReq = 4'b0100;
    step(1);
    step(64);
    chk("rst_seq_f2", 4'b0010, 2'b01, 1'b0, 4'b0000, 1'b0);
    step(1);
    step(30);
    chk("rst_seq_mid", 4'b0010, 2'b01, 1'b0, 4'b0000, 1'b1);
    rst = 1'b1;
    step(1);
    chk("mid_rst", 4'b0001, 2'b00, 1'b0, 4'b0000, 1'b0);
    rst = 1'b0; up_need = 1'b0; allReq = 4'b0000;
    step(3);
    chk("post_rst_idle", 4'b0001, 2'b00, 1'b0, 4'b0000, 1'b0);
    up_need = 1'b1; allReq = 4'b0010;
    step(64);
    chk("post_rst_t63", 4'b0001, 2'b01, 1'b0, 4'b0000, 1'b1);
    step(1);
    chk("post_rst_t64", 4'b0010, 2'b01, 1'b0, 4'b0000, 1'b0);

`ifdef ESTOP_EN
    // estop for 10 cycles mid-travel delays arrival by exactly 10 cycles
    do_reset();
    up_need = 1'b1; allReq = 4'b0010;
    step(21);
    estop = 1'b1;
    step(10);
    chk("estop_frozen", 4'b0001, 2'b01, 1'b0, 4'b0000, 1'b0);
    estop = 1'b0;
    step(43);
    chk("estop_t73", 4'b0001, 2'b01, 1'b0, 4'b0000, 1'b1);
    step(1);
    chk("estop_t74", 4'b0010, 2'b01, 1'b0, 4'b0000, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/car_motion_ctrl.md
# car_motion_ctrl

Car motion and door sequencer for the 4-storey elevator. It consumes the request processor's `up_need`/`down_need`/`allReq` outputs and drives the car floor by floor. It produces the one-hot `position` and the `ud_mode` run mode that the request processor samples, and it issues `StOpen` to the door timer, waiting for its `endOpen` pulse. It is the executing end of the request-processor interface.

## Interface
Parameters:
- `TRAVEL_CYCLES`, 64, clk cycles to travel one floor (2 s at 32 Hz); legal range ≥ 2.
- `FLOORS`, 4, floor count; fixed at 4 in this revision.

Ports:
- `clk` in 1: system clock (clk32hz domain); all logic single-clock.
- `rst` in 1: synchronous, active-high reset.
- `up_need` in 1: request processor reports a valid request above or in the up direction.
- `down_need` in 1: request processor reports a valid request below or in the down direction.
- `allReq` in 4: effective request mask, one bit per floor, bit0 = floor 1.
- `endOpen` in 1: one-cycle pulse from the door timer when the door cycle completes.
- `position` out 4: one-hot current floor.
- `ud_mode` out 2: 00 stop, 01 up, 10 down; 11 never driven.
- `StOpen` out 1: door-open request, held high until `endOpen`.
- `arrive_clr` out 4: one-cycle strobe equal to `position` on door opening, used to clear served requests.
- `moving` out 1: high while in MOVE.

## Operation
- States: IDLE, MOVE, CHECK, DOOR, RESUME.
- Reset values:
  - state IDLE
  - `position`=4'b0001
  - `ud_mode`=00
  - `StOpen`=0
  - `arrive_clr`=0
  - `moving`=0
  - travel counter 0
- IDLE: `ud_mode`=00. Decisions are evaluated in this priority order:
  1. `allReq & position` ≠ 0 → DOOR.
  2. `up_need` and not top floor → MOVE, `ud_mode`=01.
  3. `down_need` and not floor 1 → MOVE, `ud_mode`=10.
  4. Otherwise stay in IDLE.
- MOVE:
  - Counter counts 0..`TRAVEL_CYCLES`-1.
  - At terminal count, `position` shifts left (up) or right (down) by one, the counter clears, and the state goes to CHECK.
- CHECK: one cycle, `ud_mode` held.
  - `allReq & position` ≠ 0 → DOOR.
  - Else same-direction need still high and not at end floor → MOVE.
  - Else → IDLE.
- DOOR:
  - On entry, `StOpen`=1 and `arrive_clr`=`position` for exactly the entry cycle.
  - `ud_mode` is held at its entry value.
  - On `endOpen`=1, `StOpen` drops and the state goes to RESUME.
- RESUME: one cycle, then:
  - same-direction need and not end floor → MOVE;
  - else opposite need and not end floor → MOVE with reversed `ud_mode`;
  - else → IDLE.
- End-floor guard: at floor 4, up moves are never started; at floor 1, down moves are never started. `position` is always exactly one-hot.
- `up_need` and `down_need` both high in IDLE: up wins.
- `endOpen` outside DOOR is ignored.
- Request inputs change during MOVE: they have no effect until CHECK.

## Timing
- IDLE→MOVE: one cycle after `up_need`/`down_need` is sampled; `moving` rises the same edge.
- Floor advance: `position` updates exactly `TRAVEL_CYCLES` cycles after MOVE entry.
- CHECK→DOOR: `StOpen` is high `TRAVEL_CYCLES`+1 cycles after MOVE entry.
- `StOpen` falls on the edge after `endOpen` is sampled high; RESUME→MOVE adds one more cycle.
- `rst` mid-operation (any state, including mid-travel): next edge restores all reset values; no partial counter is retained.

## Configuration
- `ESTOP_EN` defined:
  - Adds input `estop` (1 bit).
  - While `estop`=1, state, counter and `position` freeze and `moving`=0.
  - `StOpen` is held at its current value.
  - On release, operation resumes where it stopped.
- `ESTOP_EN` undefined: no port and no freeze logic.

## Structure
- Shared package `elev_pkg`:
  - state enum;
  - `UD_STOP`/`UD_UP`/`UD_DOWN` constants (2'b00/01/10);
  - `FLOOR_BOT`=4'b0001 and `FLOOR_TOP`=4'b1000 one-hot constants.
- Sub-module `travel_timer`: counter with `start`, `freeze`, and a `done` pulse at `TRAVEL_CYCLES`-1; width is $clog2(`TRAVEL_CYCLES`).

## Test plan
- Reset, then `allReq`=4'b0100 with `up_need`=1:
  - `ud_mode`=01;
  - `position` reaches 0010 after 64 cycles and 0100 after 129 cycles (64 + CHECK + 64);
  - `StOpen` rises the next cycle with `arrive_clr`=0100.
- At floor 4 with `up_need`=1 and `down_need`=0: no move; `ud_mode` stays 00 and `position` stays 1000.
- In DOOR at floor 3, `endOpen` pulse with `down_need`=1 and `up_need`=0: RESUME, then MOVE with `ud_mode`=10, reaching 0010 after 64 cycles.
- `allReq`=4'b0001 at floor 1 in IDLE: DOOR immediately, `ud_mode`=00, `arrive_clr`=0001 for one cycle.
- `rst` asserted at travel count 30 between floors 2 and 3: next cycle `position`=0001, IDLE, all outputs at reset values.
- With `ESTOP_EN`, `estop` high for 10 cycles mid-travel: floor arrival is delayed by exactly 10 cycles.
